rb_window_former: RTL and testbench

Downstream stage of the row-buffer controller. It takes one column of K pixels per cycle from the BRAM row-buffer read port and rotates it into logical row order using the controller's `steer` value. It then shifts the column into a K×K sliding-window register and flags each fully populated window for the neighbourhood-processing kernel. It also counts columns and rows, and signals end of frame.

---
 rtl/rb_window_former_pkg.sv | 23 ++
 rtl/rb_col_rotator.sv | 55 +++++
 rtl/rb_window_former.sv | 131 +++++++++++++
 tb/tb_rb_window_former.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rb_window_former_pkg.sv
// Shared types and defaults for the row-buffer window former.
// Holds the FSM encoding and the modular index helper used by the column rotator.
package rb_window_former_pkg;

    localparam int DEF_K     = 3;
    localparam int DEF_PIX_W = 8;
    localparam int DEF_IMG_W = 64;
    localparam int DEF_IMG_H = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Both operands are below modulus, so one conditional subtract is a full mod.
    function automatic int wrap_index(input int base, input int off, input int modulus);
        int sum;
        sum = base + off;
        return (sum >= modulus) ? (sum - modulus) : sum;
    endfunction

endpackage

// File: rtl/rb_col_rotator.sv
// Rotates one physical buffer column into logical row order and registers it.
// An out-of-range steer value is treated as zero and latched as a sticky error.
module rb_col_rotator
    import rb_window_former_pkg::*;
#(
    parameter int K       = DEF_K,
    parameter int PIX_W   = DEF_PIX_W,
    parameter int STEER_W = $clog2(K)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [K*PIX_W-1:0]   col_in,
    input  logic [STEER_W-1:0]   steer,
    output logic [K*PIX_W-1:0]   col_out,
    output logic                 col_valid,
    output logic                 steer_err
);

    logic               steer_bad;
    logic [K*PIX_W-1:0] rotated;
    int                 base;

    assign steer_bad = (int'(steer) >= K);

    // Logical row r comes from physical line (steer + r) mod K.
    always_comb begin
        rotated = '0;
        base    = steer_bad ? 0 : int'(steer);
        for (int r = 0; r < K; r++) begin
            rotated[r*PIX_W +: PIX_W] = col_in[wrap_index(base, r, K)*PIX_W +: PIX_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_out   <= '0;
            col_valid <= 1'b0;
            steer_err <= 1'b0;
        end else if (clr) begin
            col_valid <= 1'b0;
            steer_err <= 1'b0;
        end else begin
            col_valid <= en;
            if (en) begin
                col_out <= rotated;
                if (steer_bad) begin
                    steer_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rb_window_former.sv
// Shifts rotated buffer columns into a KxK sliding window and flags complete windows.
// Tracks window position within the frame and pulses frame_done on the final window.
module rb_window_former
    import rb_window_former_pkg::*;
#(
    parameter int K       = DEF_K,
    parameter int PIX_W   = DEF_PIX_W,
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int STEER_W = $clog2(K)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [K*PIX_W-1:0]        col_in,
    input  logic [STEER_W-1:0]        steer,
    output logic [K*K*PIX_W-1:0]      win,
    output logic                      win_valid,
    output logic [$clog2(IMG_W)-1:0]  win_col,
    output logic [$clog2(IMG_H)-1:0]  win_row,
    output logic                      frame_done,
    output logic                      steer_err
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_t             state_q;
    state_t             state_d;
    logic               rot_en;
    logic               rot_valid;
    logic [K*PIX_W-1:0] rot_col;
    logic [CW-1:0]      col_cnt;
    logic [RW-1:0]      row_cnt;
    logic               col_fire;
    logic               col_last;
    logic               frame_last;
    logic               win_ready;

    assign rot_en = (state_q == S_RUN) && in_valid;

    rb_col_rotator #(
        .K       (K),
        .PIX_W   (PIX_W),
        .STEER_W (STEER_W)
    ) u_rotator (
        .clk       (clk),
        .rst       (rst),
        .clr       (start),
        .en        (rot_en),
        .col_in    (col_in),
        .steer     (steer),
        .col_out   (rot_col),
        .col_valid (rot_valid),
        .steer_err (steer_err)
    );

    // Columns still in the rotator when the frame ends are dropped here.
    assign col_fire   = rot_valid && (state_q == S_RUN);
    assign col_last   = (col_cnt == CW'(IMG_W - 1));
    assign frame_last = col_fire && col_last && (row_cnt == RW'(IMG_H - K));
    assign win_ready  = (col_cnt >= CW'(K - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_RUN;
        end else if (frame_last) begin
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win <= '0;
        end else if (col_fire && !start) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win[(r*K + c)*PIX_W +: PIX_W] <= win[(r*K + c + 1)*PIX_W +: PIX_W];
                end
                win[(r*K + K - 1)*PIX_W +: PIX_W] <= rot_col[r*PIX_W +: PIX_W];
            end
        end
    end

    // Window rows never straddle an image row, so the first K-1 columns of each row stay silent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            win_valid  <= 1'b0;
            win_col    <= '0;
            win_row    <= '0;
            frame_done <= 1'b0;
        end else if (start) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (col_fire) begin
                if (win_ready) begin
                    win_valid <= 1'b1;
                    win_col   <= col_cnt - CW'(K - 1);
                    win_row   <= row_cnt;
                end
                frame_done <= frame_last;
                if (!frame_last) begin
                    if (col_last) begin
                        col_cnt <= '0;
                        row_cnt <= row_cnt + RW'(1);
                    end else begin
                        col_cnt <= col_cnt + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rb_window_former.sv
// Scoreboard bench for rb_window_former: a reference model queues every expected window
// with its due cycle, and a negedge monitor pops and compares as the DUT emits them.
module tb_rb_window_former;

    localparam int K     = 3;
    localparam int PIX_W = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int CW    = K * PIX_W;
    localparam int WW    = K * K * PIX_W;

    typedef struct {
        logic [WW-1:0] win;
        int            col;
        int            row;
        logic          done;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [CW-1:0] col_in = '0;
    logic [1:0]    steer = '0;
    logic [WW-1:0] win;
    logic          win_valid;
    logic [2:0]    win_col;
    logic [2:0]    win_row;
    logic          frame_done;
    logic          steer_err;

    exp_t          sb[$];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            win_count = 0;
    int            done_count = 0;
    int            m_col = 0;
    int            m_row = 0;
    bit            m_active = 1'b0;
    logic [CW-1:0] hist [K];

    localparam logic [7:0] PA = 8'hA1;
    localparam logic [7:0] PB = 8'hB2;
    localparam logic [7:0] PC = 8'hC3;

    rb_window_former #(
        .K     (K),
        .PIX_W (PIX_W),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .col_in     (col_in),
        .steer      (steer),
        .win        (win),
        .win_valid  (win_valid),
        .win_col    (win_col),
        .win_row    (win_row),
        .frame_done (frame_done),
        .steer_err  (steer_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] rnd_col();
        return CW'($urandom);
    endfunction

    function automatic logic [WW-1:0] build_win();
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                w[(r*K + c)*PIX_W +: PIX_W] = hist[c][r*PIX_W +: PIX_W];
            end
        end
        return w;
    endfunction

    // Drives one cycle; lc is the column in logical row order, placed onto physical lines.
    task automatic applyStimulus(input logic v, input logic [CW-1:0] lc, input int s);
        int   se;
        exp_t e;
        se       = (s >= K) ? 0 : s;
        in_valid = v;
        steer    = 2'(s);
        for (int r = 0; r < K; r++) begin
            col_in[((se + r) % K)*PIX_W +: PIX_W] = lc[r*PIX_W +: PIX_W];
        end
        if (v && m_active) begin
            for (int c = 0; c < K - 1; c++) hist[c] = hist[c + 1];
            hist[K-1] = lc;
            if (m_col >= K - 1) begin
                e.win  = build_win();
                e.col  = m_col - (K - 1);
                e.row  = m_row;
                e.done = (m_row == IMG_H - K) && (m_col == IMG_W - 1);
                e.cyc  = cyc + 2;
                sb.push_back(e);
            end
            if ((m_row == IMG_H - K) && (m_col == IMG_W - 1)) begin
                m_active = 1'b0;
            end else if (m_col == IMG_W - 1) begin
                m_col = 0;
                m_row++;
            end else begin
                m_col++;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStart(input logic v, input logic [CW-1:0] lc);
        start    = 1'b1;
        in_valid = v;
        col_in   = lc;
        steer    = '0;
        while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
        m_col    = 0;
        m_row    = 0;
        m_active = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, '0, 0);
    endtask

    task automatic checkFrame(input string tag);
        checkOutput({tag, "_windows"}, win_count, 24);
        checkOutput({tag, "_frame_done"}, done_count, 1);
        checkOutput({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checkOutput("missing_win_cyc", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (win_valid) begin
                win_count++;
                if (frame_done) done_count++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_win", win_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("win_cyc", cyc, e.cyc);
                    checkOutput("win_data", win, e.win);
                    checkOutput("win_col", win_col, e.col);
                    checkOutput("win_row", win_row, e.row);
                    checkOutput("frame_done", frame_done, e.done);
                end
            end else if (frame_done) begin
                checkOutput("done_without_valid", frame_done, 1'b0);
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int c = 0; c < K; c++) hist[c] = '0;

        #2;
        checkOutput("rst_win", win, '0);
        checkOutput("rst_win_valid", win_valid, 1'b0);
        checkOutput("rst_win_col", win_col, 3'd0);
        checkOutput("rst_win_row", win_row, 3'd0);
        checkOutput("rst_frame_done", frame_done, 1'b0);
        checkOutput("rst_steer_err", steer_err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] idle columns before start");
        applyStimulus(1'b1, rnd_col(), 0);
        applyStimulus(1'b1, rnd_col(), 1);
        idle(3);

        $display("[TB] frame 1: contiguous, steer 0");
        win_count  = 0;
        done_count = 0;
        applyStart(1'b0, '0);
        for (int i = 0; i < (IMG_H - K + 1) * IMG_W; i++) applyStimulus(1'b1, rnd_col(), 0);
        idle(4);
        checkFrame("frame1");
        checkOutput("frame1_steer_err", steer_err, 1'b0);

        $display("[TB] frame 2: rotation then 50%% gaps");
        win_count  = 0;
        done_count = 0;
        applyStart(1'b0, '0);
        repeat (3) applyStimulus(1'b1, {PA, PC, PB}, 1);
        idle(2);
        checkOutput("rot1_r0", win[(0*K + 2)*PIX_W +: PIX_W], PB);
        checkOutput("rot1_r1", win[(1*K + 2)*PIX_W +: PIX_W], PC);
        checkOutput("rot1_r2", win[(2*K + 2)*PIX_W +: PIX_W], PA);
        applyStimulus(1'b1, {PB, PA, PC}, 2);
        idle(2);
        checkOutput("rot2_r0", win[(0*K + 2)*PIX_W +: PIX_W], PC);
        checkOutput("rot2_r1", win[(1*K + 2)*PIX_W +: PIX_W], PA);
        checkOutput("rot2_r2", win[(2*K + 2)*PIX_W +: PIX_W], PB);
        checkOutput("rot2_shift", win[(0*K + 1)*PIX_W +: PIX_W], PB);
        for (int i = 4; i < (IMG_H - K + 1) * IMG_W; i++) begin
            applyStimulus(1'b1, rnd_col(), int'($urandom_range(0, 2)));
            applyStimulus(1'b0, rnd_col(), 0);
        end
        idle(4);
        checkFrame("frame2");

        $display("[TB] frame 3: restart mid-frame");
        applyStart(1'b0, '0);
        for (int i = 0; i < 2 * IMG_W + 5; i++) applyStimulus(1'b1, rnd_col(), int'($urandom_range(0, 2)));
        applyStart(1'b1, rnd_col());
        checkOutput("restart_gap0", win_valid, 1'b0);
        idle(1);
        checkOutput("restart_gap1", win_valid, 1'b0);
        win_count  = 0;
        done_count = 0;
        for (int i = 0; i < (IMG_H - K + 1) * IMG_W; i++) applyStimulus(1'b1, rnd_col(), int'($urandom_range(0, 2)));
        repeat (4) applyStimulus(1'b1, rnd_col(), 0);
        idle(4);
        checkFrame("frame3");

        $display("[TB] steer error handling");
        applyStart(1'b0, '0);
        applyStimulus(1'b1, {PC, PB, PA}, 3);
        checkOutput("steer_err_set", steer_err, 1'b1);
        repeat (2) applyStimulus(1'b1, {PC, PB, PA}, 0);
        idle(2);
        checkOutput("steer3_r0", win[(0*K + 0)*PIX_W +: PIX_W], PA);
        checkOutput("steer3_r1", win[(1*K + 0)*PIX_W +: PIX_W], PB);
        checkOutput("steer3_r2", win[(2*K + 0)*PIX_W +: PIX_W], PC);
        checkOutput("steer_err_sticky", steer_err, 1'b1);
        applyStart(1'b0, '0);
        checkOutput("steer_err_cleared", steer_err, 1'b0);

        $display("[TB] asynchronous reset mid-frame");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, rnd_col(), int'($urandom_range(0, 2)));
        #2;
        rst = 1'b1;
        sb.delete();
        m_active = 1'b0;
        #1;
        checkOutput("arst_win", win, '0);
        checkOutput("arst_win_valid", win_valid, 1'b0);
        checkOutput("arst_win_col", win_col, 3'd0);
        checkOutput("arst_frame_done", frame_done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) applyStimulus(1'b1, rnd_col(), 0);
        idle(4);
        checkOutput("post_rst_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
